// File: rtl/io_uart_responder_if.sv
// I/O bus between the control unit (master) and a memory-mapped responder (slave).
// data_out and hit come back from the responder on the IN path.
interface io_uart_responder_if;
   logic [7:0] address;
   logic [7:0] data_in;
   logic       write_enable;
   logic       read_enable;
   logic [7:0] data_out;
   logic       hit;

   modport master (
      output address, data_in, write_enable, read_enable,
      input  data_out, hit
   );

   modport slave (
      input  address, data_in, write_enable, read_enable,
      output data_out, hit
   );
endinterface

// File: rtl/io_uart_responder.sv
// Memory-mapped 8N1 UART responder: DATA/STATUS/DIV_LO/DIV_HI at BASE_ADDR..+3,
// with TX and RX FIFOs between the CPU I/O bus and the serial lines.
module io_uart_responder #(
   parameter logic [7:0] BASE_ADDR     = 8'h20,
   parameter int         DIVISOR_RESET = 434,
   parameter int         FIFO_DEPTH    = 4
) (
   input  logic clock,
   input  logic reset_s2_n,
   io_uart_responder_if.slave bus,
   input  logic uart_rx,
   output logic uart_tx
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   logic [7:0]  offset;
   logic [1:0]  reg_sel;
   logic        we_q, re_q, wr_fire, rd_fire;
   logic [15:0] div_reg, eff_div;

   assign offset  = bus.address - BASE_ADDR;
   assign reg_sel = offset[1:0];
   assign bus.hit = (offset[7:2] == 6'd0);

   // Enables stay high across stalled manual-clock cycles, so only the rising edge acts.
   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         we_q <= 1'b0;
         re_q <= 1'b0;
      end else begin
         we_q <= bus.write_enable;
         re_q <= bus.read_enable;
      end
   end

   assign wr_fire = bus.write_enable & ~we_q & bus.hit;
   assign rd_fire = bus.read_enable  & ~re_q & bus.hit;

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         div_reg <= 16'(DIVISOR_RESET);
      end else if (wr_fire && reg_sel == 2'd2) begin
         div_reg[7:0] <= bus.data_in;
      end else if (wr_fire && reg_sel == 2'd3) begin
         div_reg[15:8] <= bus.data_in;
      end
   end

   assign eff_div = (div_reg < 16'd4) ? 16'd4 : div_reg;

   // TX FIFO
   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr, tx_rd;
   logic        tx_empty, tx_full, tx_push, tx_pop;
   logic [7:0]  tx_head;

   assign tx_empty = (tx_wr == tx_rd);
   assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
   assign tx_push  = wr_fire && (reg_sel == 2'd0) && !tx_full;
   assign tx_head  = tx_mem[tx_rd[AW-1:0]];

   always_ff @(posedge clock) begin
      if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.data_in;
   end

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         tx_wr <= '0;
         tx_rd <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      end
   end

   // RX FIFO
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] rx_wr, rx_rd;
   logic        rx_empty, rx_full, rx_push, rx_pop;
   logic [7:0]  rx_head, rx_shift;

   assign rx_empty = (rx_wr == rx_rd);
   assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
   assign rx_pop   = rd_fire && (reg_sel == 2'd0) && !rx_empty;
   assign rx_head  = rx_mem[rx_rd[AW-1:0]];

   always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
   end

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      end
   end

   // TX FSM: each state is one bit cell of tx_div cycles, latched when the frame starts.
   uart_state_t tx_state;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_cell_end, tx_idle;

   assign tx_cell_end = (tx_cnt == tx_div - 16'd1);
   assign tx_pop      = !tx_empty &&
                        ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cell_end));
   assign tx_idle     = tx_empty && (tx_state == S_IDLE);

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_div   <= 16'd4;
         tx_bit   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else if (tx_pop) begin
         tx_state <= S_START;
         tx_cnt   <= '0;
         tx_div   <= eff_div;
         tx_shift <= tx_head;
         uart_tx  <= 1'b0;
      end else if (tx_state != S_IDLE) begin
         if (!tx_cell_end) begin
            tx_cnt <= tx_cnt + 16'd1;
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               S_START: begin
                  tx_state <= S_DATA;
                  tx_bit   <= '0;
                  uart_tx  <= tx_shift[0];
               end
               S_DATA: begin
                  if (tx_bit == 3'd7) begin
                     tx_state <= S_STOP;
                     uart_tx  <= 1'b1;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= tx_shift >> 1;
                     uart_tx  <= tx_shift[1];
                  end
               end
               default: begin
                  tx_state <= S_IDLE;
                  uart_tx  <= 1'b1;
               end
            endcase
         end
      end
   end

   // RX: two-flop synchroniser plus one more stage to spot the falling start edge.
   logic rx_meta, rx_sync, rx_prev;

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   uart_state_t rx_state;
   logic [15:0] rx_cnt, rx_div;
   logic [2:0]  rx_bit;
   logic        rx_half_end, rx_cell_end, rx_stop_sample;
   logic        overrun_set, frame_set;

   assign rx_half_end    = (rx_cnt == (rx_div >> 1) - 16'd1);
   assign rx_cell_end    = (rx_cnt == rx_div - 16'd1);
   assign rx_stop_sample = (rx_state == S_STOP) && rx_cell_end;
   assign rx_push        = rx_stop_sample && rx_sync && !rx_full;
   assign overrun_set    = rx_stop_sample && rx_sync && rx_full;
   assign frame_set      = rx_stop_sample && !rx_sync;

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_div   <= 16'd4;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         case (rx_state)
            S_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= S_START;
                  rx_cnt   <= '0;
                  rx_div   <= eff_div;
               end
            end
            S_START: begin
               if (rx_half_end) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (rx_cell_end) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= S_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: begin
               if (rx_cell_end) begin
                  rx_cnt   <= '0;
                  rx_state <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // Sticky error flags; a set in the same cycle as a write-1-to-clear wins.
   logic rx_overrun, frame_err, clr_overrun, clr_frame;

   assign clr_overrun = wr_fire && (reg_sel == 2'd1) && bus.data_in[3];
   assign clr_frame   = wr_fire && (reg_sel == 2'd1) && bus.data_in[4];

   always_ff @(posedge clock or negedge reset_s2_n) begin
      if (!reset_s2_n) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_overrun <= overrun_set | (rx_overrun & ~clr_overrun);
         frame_err  <= frame_set   | (frame_err  & ~clr_frame);
      end
   end

   logic [7:0] status;
   assign status = {3'b000, frame_err, rx_overrun, !rx_empty, tx_full, tx_idle};

   always_comb begin
      bus.data_out = 8'h00;
      if (bus.hit) begin
         case (reg_sel)
            2'd0:    bus.data_out = rx_empty ? 8'h00 : rx_head;
            2'd1:    bus.data_out = status;
            2'd2:    bus.data_out = div_reg[7:0];
            default: bus.data_out = div_reg[15:8];
         endcase
      end
   end

endmodule
